// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, fetches over a req/ack handshake and holds the word in IR.
// Optional opcode filter enabled by defining IFETCH_OPFILTER_EN.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IR,
  output logic [5:0]  OP,
  output logic        ir_valid,
  output logic [31:0] pc_out,
  input  logic        ex_done,
  input  logic        Branch,
  input  logic        JMP,
  input  logic        Zero,
  output logic        illegal_op,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a fetch completes on a rising edge where imem_req and imem_ack are both high;
  // imem_req stays high and imem_addr stays stable until that edge.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  localparam logic [31:0] PC_RST = RESET_PC & ~32'h3;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        illegal_q, illegal_d;

  logic [31:0] pc4;
  logic [31:0] br_off;
  logic [31:0] jmp_tgt;
  logic [31:0] next_pc;
  logic [31:0] ir_load;
  logic        op_bad;

  assign pc4     = pc_q + 32'd4;
  assign br_off  = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
  assign jmp_tgt = {pc4[31:28], ir_q[25:0], 2'b00};

  always_comb begin
    next_pc = pc4;
    if (JMP) begin
      next_pc = jmp_tgt;
    end else if (Branch && Zero) begin
      next_pc = pc4 + br_off;
    end
  end

`ifdef IFETCH_OPFILTER_EN
  // Unsupported opcodes are replaced by an all-zero R-type word, which executes as a NOP.
  always_comb begin
    op_bad = 1'b1;
    case (imem_rdata[31:26])
      6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010: op_bad = 1'b0;
      default: op_bad = 1'b1;
    endcase
  end
  assign ir_load    = op_bad ? 32'h0 : imem_rdata;
  assign illegal_op = illegal_q;
`else
  assign op_bad     = 1'b0;
  assign ir_load    = imem_rdata;
  assign illegal_op = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    illegal_d = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          state_d   = S_HOLD;
          ir_d      = ir_load;
          illegal_d = op_bad;
        end
      end
      S_HOLD: begin
        if (ex_done) begin
          state_d = S_FETCH;
          pc_d    = next_pc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= PC_RST;
      ir_q      <= 32'h0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign IR          = ir_q;
  assign OP          = ir_q[31:26];
  assign ir_valid    = (state_q == S_HOLD);
  assign pc_out      = pc_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: scoreboard of expected fetch addresses plus per-scenario checks.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] IR;
  logic [5:0]  OP;
  logic        ir_valid;
  logic [31:0] pc_out;
  logic        ex_done;
  logic        Branch;
  logic        JMP;
  logic        Zero;
  logic        illegal_op;
  logic [1:0]  dbg_state;

  int n_cmp;
  int n_bad;
  int cyc;
  int fetch_start_cyc;
  logic [31:0] exp_q[$];

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .IR(IR), .OP(OP), .ir_valid(ir_valid), .pc_out(pc_out),
    .ex_done(ex_done), .Branch(Branch), .JMP(JMP), .Zero(Zero),
    .illegal_op(illegal_op), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // reference model
  function automatic logic [31:0] exp_ir(input logic [31:0] w);
`ifdef IFETCH_OPFILTER_EN
    case (w[31:26])
      6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010: return w;
      default: return 32'h0;
    endcase
`else
    return w;
`endif
  endfunction

  function automatic logic exp_ill(input logic [31:0] w);
`ifdef IFETCH_OPFILTER_EN
    return (exp_ir(w) == 32'h0) && (w != 32'h0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ir,
                                             input logic br, input logic jmp, input logic zero);
    logic [31:0] p4;
    p4 = pc + 32'd4;
    if (jmp) return {p4[31:28], ir[25:0], 2'b00};
    if (br && zero) return p4 + {{14{ir[15]}}, ir[15:0], 2'b00};
    return p4;
  endfunction

  // driver: one full fetch + hold + retire, caller sits at a negedge
  task automatic run_instr(input logic [31:0] instr, input int waits, input int ex_wait,
                           input logic br, input logic jmp, input logic zero, input logic spurious);
    int guard;
    logic [31:0] fa, eir, npc;
    guard = 0;
    while (imem_req !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    fetch_start_cyc = cyc;
    n_cmp++;
    if (imem_req !== 1'b1) begin
      n_bad++;
      $display("FAIL req_timeout: imem_req=%b, expected 1 within 20 cycles", imem_req);
      return;
    end
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: fetch at %h with no expected address", imem_addr);
      return;
    end
    fa = exp_q.pop_front();
    n_cmp++;
    if (imem_addr !== fa) begin
      n_bad++;
      $display("FAIL fetch_addr: got %h, expected %h", imem_addr, fa);
    end
    n_cmp++;
    if (ir_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL fetch_ir_valid: got %b, expected 0", ir_valid);
    end
    for (int w = 0; w < waits; w++) begin
      imem_ack = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== fa || ir_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL wait_state: req=%b addr=%h ir_valid=%b, expected 1 %h 0",
                 imem_req, imem_addr, ir_valid, fa);
      end
    end
    imem_ack   = 1'b1;
    imem_rdata = instr;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    eir = exp_ir(instr);
    n_cmp++;
    if (ir_valid !== 1'b1 || imem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_entry: ir_valid=%b req=%b, expected 1 0", ir_valid, imem_req);
    end
    n_cmp++;
    if (IR !== eir || OP !== eir[31:26]) begin
      n_bad++;
      $display("FAIL ir_load: IR=%h OP=%b, expected %h %b", IR, OP, eir, eir[31:26]);
    end
    n_cmp++;
    if (pc_out !== fa) begin
      n_bad++;
      $display("FAIL pc_out: got %h, expected %h", pc_out, fa);
    end
    n_cmp++;
    if (illegal_op !== exp_ill(instr)) begin
      n_bad++;
      $display("FAIL illegal_first: got %b, expected %b", illegal_op, exp_ill(instr));
    end
    for (int e = 0; e < ex_wait; e++) begin
      imem_ack   = spurious;
      imem_rdata = $urandom;
      Branch     = 1'($urandom_range(0, 1));
      JMP        = 1'($urandom_range(0, 1));
      Zero       = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_cmp++;
      if (ir_valid !== 1'b1 || IR !== eir || pc_out !== fa || illegal_op !== 1'b0 || imem_req !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_stable: ir_valid=%b IR=%h pc=%h ill=%b req=%b, expected 1 %h %h 0 0",
                 ir_valid, IR, pc_out, illegal_op, imem_req, eir, fa);
      end
    end
    imem_ack = 1'b0;
    ex_done  = 1'b1;
    Branch   = br;
    JMP      = jmp;
    Zero     = zero;
    npc = model_next(fa, eir, br, jmp, zero);
    exp_q.push_back(npc);
    @(negedge clk);
    ex_done = 1'b0;
    Branch  = 1'($urandom_range(0, 1));
    JMP     = 1'($urandom_range(0, 1));
    Zero    = 1'($urandom_range(0, 1));
    n_cmp++;
    if (ir_valid !== 1'b0 || imem_req !== 1'b1 || pc_out !== npc || illegal_op !== 1'b0) begin
      n_bad++;
      $display("FAIL retire: ir_valid=%b req=%b pc=%h ill=%b, expected 0 1 %h 0",
               ir_valid, imem_req, pc_out, illegal_op, npc);
    end
  endtask

  task automatic check_reset_values(input string tag);
    n_cmp++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || IR !== 32'h0 || OP !== 6'h0 ||
        ir_valid !== 1'b0 || pc_out !== 32'h0 || illegal_op !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: req=%b addr=%h IR=%h OP=%b v=%b pc=%h ill=%b, expected all zero",
               tag, imem_req, imem_addr, IR, OP, ir_valid, pc_out, illegal_op);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset_values");
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (imem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_release: req=%b, expected 0", imem_req);
    end
    @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_bad++;
      $display("FAIL first_req: req=%b addr=%h, expected 1 00000000", imem_req, imem_addr);
    end
    exp_q.delete();
    exp_q.push_back(32'h0);
  endtask

  task automatic test_sequential();
    int prev;
    run_instr(32'h8C01_0004, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    prev = fetch_start_cyc;
    for (int i = 0; i < 2; i++) begin
      run_instr(32'h8C01_0004, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (fetch_start_cyc - prev != 2) begin
        n_bad++;
        $display("FAIL throughput: %0d cycles per instruction, expected 2", fetch_start_cyc - prev);
      end
      prev = fetch_start_cyc;
    end
  endtask

  task automatic test_wait_states();
    run_instr(32'h8C02_0008, 3, 2, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (imem_addr !== 32'h10) begin
      n_bad++;
      $display("FAIL after_wait_addr: got %h, expected 00000010", imem_addr);
    end
  endtask

  task automatic test_beq();
    run_instr(32'h1000_FFFE, 0, 1, 1'b1, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (imem_addr !== 32'h0C) begin
      n_bad++;
      $display("FAIL beq_taken: addr=%h, expected 0000000c", imem_addr);
    end
    run_instr(32'h0000_0000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr(32'h1000_FFFE, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (imem_addr !== 32'h14) begin
      n_bad++;
      $display("FAIL beq_not_taken: addr=%h, expected 00000014", imem_addr);
    end
    run_instr(32'h0800_0010, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_fetch();
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      n_bad++;
      $display("FAIL pending_fetch: req=%b addr=%h, expected 1 00000040", imem_req, imem_addr);
    end
    void'(exp_q.pop_front());
    @(negedge clk);
    rst_n    = 1'b0;
    #1;
    check_reset_values("mid_fetch_reset");
    imem_ack   = 1'b1;
    imem_rdata = 32'hAC00_1234;
    @(negedge clk);
    check_reset_values("reset_with_ack");
    rst_n = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || ir_valid !== 1'b0 || IR !== 32'h0) begin
      n_bad++;
      $display("FAIL late_ack_ignored: req=%b addr=%h v=%b IR=%h, expected 1 00000000 0 00000000",
               imem_req, imem_addr, ir_valid, IR);
    end
    exp_q.delete();
    exp_q.push_back(32'h0);
  endtask

  task automatic test_jmp_priority();
    run_instr(32'h1000_FFFD, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (imem_addr !== 32'hFFFF_FFF8) begin
      n_bad++;
      $display("FAIL branch_wrap: addr=%h, expected fffffff8", imem_addr);
    end
    run_instr(32'h0800_0008, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (imem_addr !== 32'hF000_0020) begin
      n_bad++;
      $display("FAIL jmp_region: addr=%h, expected f0000020", imem_addr);
    end
    run_instr(32'h0800_0100, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (imem_addr !== 32'hF000_0400) begin
      n_bad++;
      $display("FAIL jmp_over_branch: addr=%h, expected f0000400", imem_addr);
    end
  endtask

  task automatic test_opfilter();
    run_instr(32'hFC00_0000, 0, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (imem_addr !== 32'hF000_0404) begin
      n_bad++;
      $display("FAIL after_filter_addr: addr=%h, expected f0000404", imem_addr);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [5];
    logic [31:0] w;
    ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
    ops[3] = 6'b000100; ops[4] = 6'b000010;
    for (int i = 0; i < 10; i++) begin
      w = {ops[$urandom_range(0, 4)], 26'($urandom)};
      run_instr(w, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc = 0;
    fetch_start_cyc = 0;
    rst_n = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    ex_done = 1'b0;
    Branch = 1'b0;
    JMP = 1'b0;
    Zero = 1'b0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_wait_states();
    test_beq();
    test_reset_mid_fetch();
    test_jmp_priority();
    test_opfilter();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit feeding the single-cycle controller: it owns the program counter, fetches instruction words from instruction memory over a req/ack handshake, and holds the fetched word in an instruction register whose OP field drives the controller. After the datapath signals that the current instruction has completed, it uses the controller's Branch and JMP outputs, plus the ALU Zero flag, to select the next PC. It is the producer side of the OP/control interface: it emits OP and consumes the resulting control decisions.

## Interface
- RESET_PC, 32'h0000_0000, PC after reset; bits [1:0] are forced to 0
- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request; high only in FETCH
- imem_addr  out  32  fetch address; equals PC and is stable while imem_req is high
- imem_ack  in  1  memory has imem_rdata valid; sampled only in FETCH
- imem_rdata  in  32  instruction word
- IR  out  32  instruction register
- OP  out  6  IR[31:26], to the controller
- ir_valid  out  1  IR holds an instruction that has not yet retired
- pc_out  out  32  PC of the instruction in IR
- ex_done  in  1  datapath has completed the IR instruction; sampled only in HOLD
- Branch  in  1  controller Branch output
- JMP  in  1  controller JMP output
- Zero  in  1  ALU zero flag
- illegal_op  out  1  one-cycle pulse on a filtered opcode (see Configuration)

## Operation
- States:
  - IDLE: reset state.
  - FETCH: asserts imem_req and waits for imem_ack.
  - HOLD: ir_valid is high; waits for ex_done.
- Transitions:
  - IDLE->FETCH on the first clock edge after reset release.
  - FETCH->HOLD on an edge where imem_ack=1; IR<=imem_rdata at that edge.
  - FETCH stays in FETCH while imem_ack=0.
  - HOLD->FETCH on an edge where ex_done=1; PC<=next_pc at that edge.
  - HOLD stays in HOLD while ex_done=0. IR, PC and outputs hold.
- next_pc, with pc4 = PC+4 (32-bit, wraps modulo 2^32):
  - JMP=1: {pc4[31:28], IR[25:0], 2'b00}. JMP has priority over Branch.
  - Branch=1 and Zero=1: pc4 + {{14{IR[15]}}, IR[15:0], 2'b00}, modulo 2^32.
  - Otherwise: pc4.
- Branch, JMP and Zero are sampled only on the ex_done edge. They are ignored at all other times.
- imem_ack in IDLE or HOLD is ignored and has no effect.
- Reset values: state=IDLE, PC=RESET_PC&~3, IR=0, OP=0, ir_valid=0, imem_req=0, imem_addr=RESET_PC&~3, illegal_op=0.
- Reset mid-fetch or mid-hold aborts immediately. The in-flight request is dropped, and a late imem_ack after reset release is ignored because the state is IDLE.

## Timing
- imem_req, ir_valid and OP are decoded from registered state or IR only. No combinational path from inputs to outputs.
- imem_ack may arrive in the first FETCH cycle. Minimum fetch is 1 cycle, and ir_valid rises the cycle after the ack edge.
- Minimum throughput is one instruction per 2 cycles: 1 FETCH cycle with immediate ack, plus 1 HOLD cycle with immediate ex_done.
- The first imem_req after reset is high 1 cycle after reset release, because IDLE lasts 1 cycle.
- pc_out updates on the ex_done edge. imem_addr shows the new PC in the following FETCH cycle.
- ir_valid falls on the ex_done edge.

## Configuration
- IFETCH_OPFILTER_EN defined:
  - On the ack edge, if imem_rdata[31:26] is not one of 000000, 100011, 101011, 000100, 000010, IR loads 32'h0 (R-type NOP) instead of imem_rdata.
  - illegal_op pulses high for exactly the first HOLD cycle.
  - pc_out still reports the faulting PC.
- Undefined: IR always loads imem_rdata unmodified, and illegal_op is tied to 0.

## Test plan
- Reset and sequential fetch: release rst_n with RESET_PC=0. ack immediately with 8C010004 (LW), ex_done=1 after 1 cycle, Branch=JMP=0.
  - Expect imem_addr 0 then 4.
  - Expect OP=100011 while ir_valid=1.
  - Expect 2 cycles per instruction.
- Wait states: hold imem_ack=0 for 3 FETCH cycles.
  - Expect imem_req high for 4 cycles.
  - Expect imem_addr stable and ir_valid=0 throughout.
  - Ignore a spurious ack during HOLD.
- BEQ: at PC=0x10, IR=1000FFFE, Branch=1.
  - With Zero=1, expect next imem_addr=0x0C.
  - With Zero=0, expect next imem_addr=0x14.
- JMP over branch: at PC=0xF0000020, IR=08000100, JMP=1 and Branch=1, Zero=1.
  - Expect next PC=0xF0000400.
- Reset mid-fetch: assert rst_n=0 during a pending FETCH at PC=0x40, then release with a late ack.
  - Expect all outputs at reset values.
  - Expect the ack ignored and the next fetch address 0.
- Opcode filter (with IFETCH_OPFILTER_EN): fetch FC000000.
  - Expect IR=0 and a 1-cycle illegal_op pulse.
  - Expect pc_out to report the faulting PC.
  - Without the macro, expect IR=FC000000 and illegal_op=0.
